// File: rtl/tvf_word_unpacker_pkg.sv
// Shared widths, packed-group field layout, FSM encoding and the group -> (t,v,f) decode
// for the t/v/f word unpacker.
package tvf_word_unpacker_pkg;
   localparam int VEF_BIT     = 8;
   localparam int T_PER_WORD  = 4;
   localparam int BIT_P_GROUP = 2 + 2*(VEF_BIT-1);
   localparam int SRAM_WORD   = T_PER_WORD*BIT_P_GROUP;
   localparam int MAX_T_LOG   = 10;

   // Group layout, MSB to LSB: {t[1:0], v[FLD_W-1:0], f[FLD_W-1:0]}
   localparam int FLD_W = VEF_BIT-1;
   localparam int F_LSB = 0;
   localparam int V_LSB = FLD_W;
   localparam int T_LSB = 2*FLD_W;

   localparam int GRP_IDX_W = $clog2(T_PER_WORD);
   localparam int WCNT_W    = MAX_T_LOG - GRP_IDX_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_STREAM = 2'd2
   } state_t;

   typedef struct packed {
      logic [1:0]         t;
      logic [VEF_BIT-1:0] v;
      logic [VEF_BIT-1:0] f;
   } tvf_elem_t;

   // Inverse of the packer's TVF_to_group: fields come back MSB zero-extended.
   function automatic tvf_elem_t group_to_tvf(input logic [BIT_P_GROUP-1:0] g);
      tvf_elem_t e;
      e.t = g[T_LSB +: 2];
      e.v = {1'b0, g[V_LSB +: FLD_W]};
      e.f = {1'b0, g[F_LSB +: FLD_W]};
      return e;
   endfunction
endpackage

// File: rtl/tvf_word_unpacker_if.sv
// Control, SRAM read-return and element-stream signals of the unpacker.
// master = unpacker side, slave = SRAM controller / PE feed / sequencer side.
interface tvf_word_unpacker_if;
   import tvf_word_unpacker_pkg::*;

   logic                 i_start;
   logic [MAX_T_LOG-1:0] i_T_size;
   logic                 o_busy;
   logic                 o_sram_request;
   logic                 i_word_valid;
   logic [SRAM_WORD-1:0] i_word;
   logic                 o_valid;
   logic                 i_update;
   logic [1:0]           o_t;
   logic [VEF_BIT-1:0]   o_v;
   logic [VEF_BIT-1:0]   o_f;
   logic                 o_t_last;

   modport master (
      input  i_start, i_T_size, i_word_valid, i_word, i_update,
      output o_busy, o_sram_request, o_valid, o_t, o_v, o_f, o_t_last
   );

   modport slave (
      output i_start, i_T_size, i_word_valid, i_word, i_update,
      input  o_busy, o_sram_request, o_valid, o_t, o_v, o_f, o_t_last
   );
endinterface

// File: rtl/tvf_word_fifo.sv
// Two-entry word FIFO. ent0 is the head; shift consumes one group from the head in place.
module tvf_word_fifo
   import tvf_word_unpacker_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [SRAM_WORD-1:0] push_data,
   input  logic                 pop,
   input  logic                 shift,
   output logic [SRAM_WORD-1:0] head,
   output logic [1:0]           count
);
   logic [SRAM_WORD-1:0] ent0, ent1;

   assign head = ent0;

   always_ff @(posedge clk) begin
      if (rst) begin
         ent0  <= '0;
         ent1  <= '0;
         count <= '0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  ent0 <= push_data;
               end else begin
                  ent1 <= push_data;
                  if (shift) ent0 <= ent0 << BIT_P_GROUP;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               ent0  <= ent1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd2) begin
                  ent0 <= ent1;
                  ent1 <= push_data;
               end else begin
                  ent0 <= push_data;
               end
            end
            default: begin
               if (shift) ent0 <= ent0 << BIT_P_GROUP;
            end
         endcase
      end
   end
endmodule

// File: rtl/tvf_word_unpacker.sv
// Fetches packed SRAM words (max 2 in flight or buffered) and streams their t/v/f groups,
// MSB group first, through a registered output stage with 1 element/cycle throughput.
module tvf_word_unpacker
   import tvf_word_unpacker_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   tvf_word_unpacker_if.master bus
);
   state_t                 state;
   logic [MAX_T_LOG-1:0]   t_size, elem_cnt;
   logic [WCNT_W-1:0]      words_total, words_req;
   logic [1:0]             outstanding;
   logic [GRP_IDX_W-1:0]   grp_idx;
   logic [MAX_T_LOG:0]     size_rnd;

   logic [1:0]             fifo_cnt;
   logic [SRAM_WORD-1:0]   fifo_head, fifo_push_data, src_word;
   logic                   fifo_push, fifo_pop, fifo_shift, fifo_empty;
   logic                   word_acc, take, is_last, word_end, req_ok;
   tvf_elem_t              nxt_elem;

   tvf_word_fifo u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (fifo_push_data),
      .pop       (fifo_pop),
      .shift     (fifo_shift),
      .head      (fifo_head),
      .count     (fifo_cnt)
   );

   // Responses with nothing outstanding, or while idle (stale after reset), are dropped.
   assign word_acc   = bus.i_word_valid & (outstanding != 2'd0) & (state != ST_IDLE);
   assign fifo_empty = (fifo_cnt == 2'd0);
   // With an empty FIFO the returning word feeds the output regs directly.
   assign src_word   = fifo_empty ? bus.i_word : fifo_head;
   assign nxt_elem   = group_to_tvf(src_word[SRAM_WORD-1 -: BIT_P_GROUP]);

   assign take = (state != ST_IDLE) & (~fifo_empty | word_acc) & (elem_cnt != t_size)
               & (~bus.o_valid | bus.i_update);
   assign is_last  = (elem_cnt == t_size - MAX_T_LOG'(1));
   assign word_end = take & ((grp_idx == GRP_IDX_W'(T_PER_WORD-1)) | is_last);

   assign fifo_push      = word_acc & ~(fifo_empty & word_end);
   assign fifo_push_data = (fifo_empty & take) ? (bus.i_word << BIT_P_GROUP) : bus.i_word;
   assign fifo_pop       = ~fifo_empty & word_end;
   assign fifo_shift     = ~fifo_empty & take & ~word_end;

   assign req_ok = (state != ST_IDLE)
                 & (({1'b0, fifo_cnt} + {1'b0, outstanding}) < 3'd2)
                 & (words_req < words_total);

   assign size_rnd = {1'b0, bus.i_T_size} + (MAX_T_LOG+1)'(T_PER_WORD-1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= ST_IDLE;
         t_size             <= '0;
         elem_cnt           <= '0;
         words_total        <= '0;
         words_req          <= '0;
         outstanding        <= '0;
         grp_idx            <= '0;
         bus.o_busy         <= 1'b0;
         bus.o_sram_request <= 1'b0;
         bus.o_valid        <= 1'b0;
         bus.o_t            <= '0;
         bus.o_v            <= '0;
         bus.o_f            <= '0;
         bus.o_t_last       <= 1'b0;
      end else begin
         bus.o_sram_request <= req_ok;
         outstanding        <= outstanding + 2'(req_ok) - 2'(word_acc);
         if (req_ok) words_req <= words_req + WCNT_W'(1);

         if (take) begin
            bus.o_valid  <= 1'b1;
            bus.o_t      <= nxt_elem.t;
            bus.o_v      <= nxt_elem.v;
            bus.o_f      <= nxt_elem.f;
            bus.o_t_last <= is_last;
            elem_cnt     <= elem_cnt + MAX_T_LOG'(1);
            grp_idx      <= word_end ? '0 : grp_idx + GRP_IDX_W'(1);
         end else if (bus.o_valid & bus.i_update) begin
            bus.o_valid  <= 1'b0;
            bus.o_t_last <= 1'b0;
         end

         unique case (state)
            ST_IDLE: begin
               if (bus.i_start && bus.i_T_size != '0) begin
                  state       <= ST_FETCH;
                  t_size      <= bus.i_T_size;
                  words_total <= WCNT_W'(size_rnd >> GRP_IDX_W);
                  words_req   <= '0;
                  elem_cnt    <= '0;
                  grp_idx     <= '0;
                  bus.o_busy  <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (take) state <= ST_STREAM;
            end
            ST_STREAM: begin
               if (bus.o_valid && bus.i_update && bus.o_t_last) begin
                  state      <= ST_IDLE;
                  bus.o_busy <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tvf_word_unpacker.sv
// Directed passes with random data/backpressure against a word-array reference model
// and a latency-queue SRAM responder.
module tb_tvf_word_unpacker;
   logic clk, rst;
   tvf_word_unpacker_if u_if ();

   tvf_word_unpacker dut (.clk(clk), .rst(rst), .bus(u_if));

   initial clk = 1'b1;
   always #5 clk = ~clk;

   typedef struct {int due; logic [63:0] data;} rsp_t;

   int          n_err = 0, n_chk = 0;
   int          cyc = 0, lat = 1, req_cnt = 0, n_req = 0;
   logic [63:0] mem [256];
   logic [17:0] got [64];
   rsp_t        rq [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // SRAM read port: each request returns mem[request#] lat cycles later, in order.
   always @(negedge clk) begin
      rsp_t r;
      int   sz;
      sz = rq.size();
      u_if.i_word_valid = 1'b0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
         u_if.i_word_valid = 1'b1;
         u_if.i_word       = rq[0].data;
         void'(rq.pop_front());
      end
      if (u_if.o_sram_request === 1'b1) begin
         check("outstanding_le_2", sz + 1 <= 2, 1);
         r.due  = cyc + lat;
         r.data = mem[req_cnt % 256];
         rq.push_back(r);
         req_cnt++;
         n_req++;
      end
   end

   // Element k: group k%4 of word k/4, counted from the MSB end; fields zero-extended.
   function automatic logic [17:0] exp_elem(input int k);
      logic [63:0] w;
      logic [15:0] g;
      w = mem[k/4];
      g = w[63 - 16*(k%4) -: 16];
      return {g[15:14], 1'b0, g[13:7], 1'b0, g[6:0]};
   endfunction

   function automatic logic [19:0] out_vec();
      return {u_if.o_valid, u_if.o_t, u_if.o_v, u_if.o_f, u_if.o_t_last};
   endfunction

   task automatic fill_random(input int nwords);
      for (int i = 0; i < nwords; i++) mem[i] = {$urandom, $urandom};
   endtask

   task automatic run_pass(input int T, input int pct_low, input int abort_at, input bit mid_start);
      int          k = 0;
      bit          stall = 0, mid_done = 0, upd;
      logic [19:0] held = '0;
      logic [17:0] obs;
      n_req = 0;
      req_cnt = 0;
      @(negedge clk);
      u_if.i_start  = 1'b1;
      u_if.i_T_size = 10'(T);
      u_if.i_update = 1'b0;
      @(negedge clk);
      u_if.i_start = 1'b0;
      check("busy_after_start", u_if.o_busy, 1);
      for (int c = 0; c < 60*T + 200 && k < T; c++) begin
         if (stall) check("hold_while_stalled", out_vec(), held);
         u_if.i_start = 1'b0;
         if (abort_at >= 0 && k == abort_at) begin
            rst = 1'b1;
            u_if.i_update = 1'b0;
            @(negedge clk);
            check("outputs_in_reset", {u_if.o_busy, u_if.o_sram_request, out_vec()}, 0);
            rst = 1'b0;
            @(negedge clk);
            check("no_req_after_reset", {u_if.o_sram_request, u_if.o_busy}, 0);
            for (int w = 0; w < 20 && rq.size() > 0; w++) @(negedge clk);
            check("stale_responses_drained", rq.size(), 0);
            repeat (2) @(negedge clk);
            check("stale_word_dropped", {u_if.o_valid, u_if.o_busy, u_if.o_sram_request}, 0);
            return;
         end
         if (mid_start && k == 2 && !mid_done) begin
            u_if.i_start  = 1'b1;
            u_if.i_T_size = 10'd3;
            mid_done = 1;
         end
         upd = ($urandom_range(99) >= pct_low);
         u_if.i_update = upd;
         if (u_if.o_valid && upd) begin
            obs = {u_if.o_t, u_if.o_v, u_if.o_f};
            check("element", obs, exp_elem(k));
            check("t_last", u_if.o_t_last, k == T-1);
            if (k < 64) got[k] = obs;
            k++;
         end
         stall = u_if.o_valid && !upd;
         held  = out_vec();
         @(negedge clk);
      end
      u_if.i_start  = 1'b0;
      u_if.i_update = 1'b0;
      check("all_elements_seen", k, T);
      check("idle_after_last", {u_if.o_busy, u_if.o_valid, u_if.o_t_last}, 0);
      check("request_count", n_req, (T + 3) / 4);
   endtask

   initial begin
      rst = 1'b1;
      u_if.i_start  = 1'b0;
      u_if.i_T_size = '0;
      u_if.i_update = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_state", {u_if.o_busy, u_if.o_sram_request, out_vec()}, 0);
      rst = 1'b0;
      @(negedge clk);

      // 8 elements, 1-cycle SRAM, no backpressure
      fill_random(2);
      mem[0][63:48] = 16'h8001;
      lat = 1;
      run_pass(8, 0, -1, 0);
      check("first_elem_t2_v0_f1", got[0], {2'd2, 8'd0, 8'd1});

      // partial last word
      fill_random(2);
      run_pass(5, 0, -1, 0);

      // backpressure and 4-cycle SRAM latency
      fill_random(5);
      lat = 4;
      run_pass(20, 30, -1, 0);

      // saturated fields, all t codes
      mem[0] = 64'h3FFF_7FFF_BFFF_FFFF;
      lat = 2;
      run_pass(4, 0, -1, 0);
      for (int i = 0; i < 4; i++) check("max_fields", got[i], {i[1:0], 8'h7F, 8'h7F});

      // zero-size start is ignored
      n_req = 0;
      @(negedge clk);
      u_if.i_start  = 1'b1;
      u_if.i_T_size = 10'd0;
      @(negedge clk);
      u_if.i_start = 1'b0;
      repeat (5) @(negedge clk);
      check("zero_size_not_busy", u_if.o_busy, 0);
      check("zero_size_no_request", n_req, 0);

      // second start mid-pass is ignored
      fill_random(3);
      run_pass(10, 20, -1, 1);

      // reset mid-pass with responses still in flight, then a clean pass
      fill_random(3);
      lat = 4;
      run_pass(12, 0, 3, 0);
      fill_random(1);
      lat = 1;
      run_pass(4, 0, -1, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1);
   end
endmodule
